multi_btn_debouncer: RTL and testbench

- Parametrised N-channel push-button conditioner for the UART tool front panel.
- Per channel: 2-flop synchroniser, counter-based stability filter, and a 4-state FSM. Produces a clean level, a one-cycle press pulse and a one-cycle release pulse.
- Runs on the system clock with a per-channel counter, with no divided clock. It feeds the command/transmit control logic directly.

---
 rtl/multi_btn_debouncer.sv | 184 ++++++++++++++++++
 tb/tb_multi_btn_debouncer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_btn_debouncer.sv
// N-channel push-button conditioner: 2-flop synchroniser, stability counter and 4-state FSM per channel.
// Optional auto-repeat of press_pulse while a button is held is enabled by defining AUTOREPEAT_EN.
module multi_btn_debouncer #(
    parameter int NUM_BTNS      = 5,
    parameter int STABLE_CYCLES = 1000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] btn,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] press_pulse,
    output logic [NUM_BTNS-1:0] release_pulse,
    output logic                any_press
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_e;

    if (NUM_BTNS < 1 || STABLE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("multi_btn_debouncer: illegal parameter value");
    end

    logic [NUM_BTNS-1:0] sync1_q;
    logic [NUM_BTNS-1:0] btn_sync_q;

    state_e              state_q [NUM_BTNS];
    state_e              state_d [NUM_BTNS];
    logic [CNT_W-1:0]    cnt_q   [NUM_BTNS];
    logic [CNT_W-1:0]    cnt_d   [NUM_BTNS];
    logic [NUM_BTNS-1:0] level_q,   level_d;
    logic [NUM_BTNS-1:0] press_q,   press_d;
    logic [NUM_BTNS-1:0] release_q, release_d;
    logic                any_q,     any_d;

`ifdef AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(REP_MAX + 1);
    localparam logic [TMR_W-1:0] TMR_DELAY  = TMR_W'(REPEAT_DELAY);
    localparam logic [TMR_W-1:0] TMR_PERIOD = TMR_W'(REPEAT_PERIOD);

    // The timer restarts after every repeat pulse; rep_phase selects the first delay or the period.
    logic [TMR_W-1:0]    tmr_q [NUM_BTNS];
    logic [TMR_W-1:0]    tmr_d [NUM_BTNS];
    logic [NUM_BTNS-1:0] rep_phase_q, rep_phase_d;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        for (int i = 0; i < NUM_BTNS; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            level_d[i]   = level_q[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
`ifdef AUTOREPEAT_EN
            tmr_d[i]       = tmr_q[i];
            rep_phase_d[i] = rep_phase_q[i];
`endif

            case (state_q[i])
                IDLE: begin
                    if (btn_sync_q[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b1;
                        press_d[i] = 1'b1;
`ifdef AUTOREPEAT_EN
                        tmr_d[i]       = '0;
                        rep_phase_d[i] = 1'b0;
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!btn_sync_q[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = CNT_ONE;
                    end
`ifdef AUTOREPEAT_EN
                    else if (tmr_q[i] + TMR_W'(1) == (rep_phase_q[i] ? TMR_PERIOD : TMR_DELAY)) begin
                        press_d[i]     = 1'b1;
                        tmr_d[i]       = '0;
                        rep_phase_d[i] = 1'b1;
                    end else begin
                        tmr_d[i] = tmr_q[i] + TMR_W'(1);
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (btn_sync_q[i]) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]   = IDLE;
                        cnt_d[i]     = '0;
                        level_d[i]   = 1'b0;
                        release_d[i] = 1'b1;
`ifdef AUTOREPEAT_EN
                        tmr_d[i]       = '0;
                        rep_phase_d[i] = 1'b0;
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
        any_d = |press_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            btn_sync_q <= '0;
            level_q    <= '0;
            press_q    <= '0;
            release_q  <= '0;
            any_q      <= 1'b0;
            // NOTE: the per-channel arrays are control state, not storage, so they must be reset too.
            for (int i = 0; i < NUM_BTNS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q    <= btn;
            btn_sync_q <= sync1_q;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            any_q      <= any_d;
            for (int i = 0; i < NUM_BTNS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

`ifdef AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_phase_q <= '0;
            for (int i = 0; i < NUM_BTNS; i++) begin
                tmr_q[i] <= '0;
            end
        end else begin
            rep_phase_q <= rep_phase_d;
            for (int i = 0; i < NUM_BTNS; i++) begin
                tmr_q[i] <= tmr_d[i];
            end
        end
    end
`endif

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign any_press     = any_q;

endmodule

// File: tb/tb_multi_btn_debouncer.sv
// Self-checking bench for multi_btn_debouncer: directed test-plan scenarios plus random bouncing,
// compared every cycle against a sliding-window reference model (honours AUTOREPEAT_EN).
module tb_multi_btn_debouncer;

    localparam int NB = 4;
    localparam int SC = 8;
    localparam int RD = 20;
    localparam int RP = 5;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn   = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] release_pulse;
    logic          any_press;

    multi_btn_debouncer #(
        .NUM_BTNS     (NB),
        .STABLE_CYCLES(SC),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn          (btn),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .any_press    (any_press)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: a button sample reaches the filter two edges after capture; the level flips
    // once the last SC filter samples all disagree with it. Auto-repeat counts uninterrupted held edges.
    bit            hist [NB][$];
    bit            win  [NB][$];
    bit            m_level [NB];
    int            m_held  [NB];
    logic [NB-1:0] exp_level, exp_press, exp_rel;

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            hist[i].delete();
            hist[i].push_back(1'b0);
            hist[i].push_back(1'b0);
            win[i].delete();
            m_level[i] = 1'b0;
            m_held[i]  = 0;
        end
        exp_level = '0;
        exp_press = '0;
        exp_rel   = '0;
    endtask

    task automatic model_edge(input logic [NB-1:0] b);
        for (int i = 0; i < NB; i++) begin
            bit samp;
            bit prev;
            bit all_diff;
            samp = hist[i].pop_front();
            hist[i].push_back(b[i]);
            prev = (win[i].size() > 0) ? win[i][$] : 1'b0;
            exp_press[i] = 1'b0;
            exp_rel[i]   = 1'b0;
`ifdef AUTOREPEAT_EN
            if (m_level[i] && prev && samp) begin
                m_held[i]++;
                if (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RP == 0))
                    exp_press[i] = 1'b1;
            end
`else
            if (prev && samp) m_held[i]++;
`endif
            win[i].push_back(samp);
            if (win[i].size() > SC) void'(win[i].pop_front());
            if (win[i].size() == SC) begin
                all_diff = 1'b1;
                foreach (win[i][k]) if (win[i][k] == m_level[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[i] = ~m_level[i];
                    m_held[i]  = 0;
                    if (m_level[i]) exp_press[i] = 1'b1;
                    else            exp_rel[i]   = 1'b1;
                end
            end
            exp_level[i] = m_level[i];
        end
    endtask

    // Event bookkeeping for the directed scenarios, relative to mark().
    int cyc;
    int first_press [NB];
    int first_rel   [NB];
    int first_any;
    int any_count;
    int p0_q[$];

    task automatic mark();
        cyc = 0;
        for (int i = 0; i < NB; i++) begin
            first_press[i] = -1;
            first_rel[i]   = -1;
        end
        first_any = -1;
        any_count = 0;
        p0_q.delete();
    endtask

    task automatic step(input logic [NB-1:0] b);
        btn = b;
        @(posedge clk);
        if (rst_n) model_edge(b);
        else       model_reset();
        @(negedge clk);
        cyc++;
        check("btn_level",     32'(btn_level),     32'(exp_level));
        check("press_pulse",   32'(press_pulse),   32'(exp_press));
        check("release_pulse", 32'(release_pulse), 32'(exp_rel));
        check("any_press",     32'(any_press),     32'(|exp_press));
        for (int i = 0; i < NB; i++) begin
            if (press_pulse[i]   && first_press[i] < 0) first_press[i] = cyc;
            if (release_pulse[i] && first_rel[i]   < 0) first_rel[i]   = cyc;
        end
        if (any_press) begin
            any_count++;
            if (first_any < 0) first_any = cyc;
        end
        if (press_pulse[0]) p0_q.push_back(cyc);
    endtask

    task automatic hold(input logic [NB-1:0] b, input int n);
        for (int k = 0; k < n; k++) step(b);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before any clock edge.
    task automatic pulse_reset(input logic [NB-1:0] b, input int n);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_level",   32'(btn_level),     32'd0);
        check("async_rst_press",   32'(press_pulse),   32'd0);
        check("async_rst_release", 32'(release_pulse), 32'd0);
        check("async_rst_any",     32'(any_press),     32'd0);
        model_reset();
        hold(b, n);
        rst_n = 1'b1;
    endtask

    initial begin
        int seg [NB];
        logic [NB-1:0] cur;

        model_reset();
        mark();
        hold('0, 3);
        rst_n = 1'b1;
        hold('0, 3);

        // Clean press and release on channel 0.
        mark();
        hold(4'b0001, 30);
        check("clean_press_cycle", 32'(first_press[0]), 32'd10);
        check("clean_other_quiet", 32'(first_press[1] + first_press[2] + first_press[3]), 32'(-3));
        mark();
        hold(4'b0000, 14);
        check("clean_release_cycle", 32'(first_rel[0]), 32'd10);

        // Bounce on channel 1, then a stable high.
        mark();
        for (int k = 0; k < 30; k++) step(((k / 3) % 2 == 0) ? 4'b0010 : 4'b0000);
        check("bounce_no_pulse", 32'(first_press[1]), 32'(-1));
        mark();
        hold(4'b0010, 14);
        check("bounce_press_cycle", 32'(first_press[1]), 32'd10);
        hold(4'b0000, 14);

        // Seven-cycle glitches: high glitch while idle, low glitch while held.
        mark();
        hold(4'b0100, 7);
        hold(4'b0000, 14);
        check("glitch_high_rejected", 32'(first_press[2]), 32'(-1));
        hold(4'b0100, 14);
        mark();
        hold(4'b0000, 7);
        hold(4'b0100, 6);
        check("glitch_low_rejected", 32'(first_rel[2]), 32'(-1));
        hold(4'b0000, 14);

        // Simultaneous press on channels 1 and 3.
        mark();
        hold(4'b1010, 14);
        check("simul_press_ch1", 32'(first_press[1]), 32'd10);
        check("simul_press_ch3", 32'(first_press[3]), 32'd10);
        check("simul_any_cycle", 32'(first_any), 32'd10);
        check("simul_any_count", 32'(any_count), 32'd1);
        hold(4'b0000, 14);

        // Reset during PRESS_WAIT and during HELD, button held through release.
        hold(4'b0001, 5);
        pulse_reset(4'b0001, 2);
        mark();
        hold(4'b0001, 14);
        check("rst_pw_press_cycle", 32'(first_press[0]), 32'd10);
        pulse_reset(4'b0001, 2);
        mark();
        hold(4'b0001, 14);
        check("rst_held_press_cycle", 32'(first_press[0]), 32'd10);
        hold(4'b0000, 14);

        // 37-cycle hold on channel 0: auto-repeat stimulus.
        mark();
        hold(4'b0001, 37);
`ifdef AUTOREPEAT_EN
        check("rep_pulse_count", 32'(p0_q.size()), 32'd3);
        if (p0_q.size() == 3) begin
            check("rep_pulse_0", 32'(p0_q[0]), 32'd10);
            check("rep_pulse_1", 32'(p0_q[1]), 32'd30);
            check("rep_pulse_2", 32'(p0_q[2]), 32'd35);
        end
`else
        check("rep_pulse_count", 32'(p0_q.size()), 32'd1);
        if (p0_q.size() == 1) check("rep_pulse_0", 32'(p0_q[0]), 32'd10);
`endif
        mark();
        hold(4'b0000, 14);
        check("rep_release_cycle", 32'(first_rel[0]), 32'd10);

        // Random bouncing on all channels with occasional resets.
        cur = '0;
        for (int i = 0; i < NB; i++) seg[i] = $urandom_range(14, 1);
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NB; i++) begin
                if (seg[i] == 0) begin
                    cur[i] = ~cur[i];
                    seg[i] = $urandom_range(14, 1);
                end
                seg[i]--;
            end
            step(cur);
            if (k % 1000 == 999) pulse_reset(cur, $urandom_range(3, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
